floo_vc_output_port: RTL

Transmit side of the credit-based virtual-channel link between routers. The block sits behind the switch of each output port of `floo_vc_router`. It holds one credit counter per downstream VC and selects the outgoing VC. It stamps the VC id into the flit header and registers the flit onto the link. It consumes the `credit_v`/`credit_id` returns that the downstream input port emits, and exposes per-VC credit availability to the router's VC selection logic.

---
 rtl/floo_vc_pkg.sv | 45 ++++
 rtl/floo_vc_credit_counter.sv | 56 +++++
 rtl/floo_vc_output_port.sv | 116 +++++++++++
 3 files changed

// File: rtl/floo_vc_pkg.sv
// Shared VC link definitions: credit counter sizing, VC id type, default flit
// layout and the FVADA output-VC selection used by the router and output ports.
package floo_vc_pkg;

    localparam int unsigned NumVCWidth = 2;
    localparam int unsigned MaxNumVC   = 8;
    localparam int unsigned MaxVCIdW   = 3;

    typedef logic [NumVCWidth-1:0] vc_id_t;

    typedef struct packed {
        vc_id_t     vc_id;
        logic [5:0] dst_id;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [31:0] payload;
    } flit_t;

    function automatic int unsigned cnt_width(input int unsigned vc_depth);
        return $clog2(vc_depth + 1);
    endfunction

    // Preferred VC when it is eligible, otherwise the lowest-index eligible VC.
    function automatic logic [MaxVCIdW-1:0] fvada_select(input logic [MaxNumVC-1:0] elig,
                                                         input logic [MaxVCIdW-1:0] pref);
        logic [MaxVCIdW-1:0] sel;
        sel = pref;
        if (!elig[pref]) begin
            sel = 3'd0;
            for (int i = MaxNumVC - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    sel = MaxVCIdW'(i);
                end else begin
                    sel = sel;
                end
            end
        end else begin
            sel = pref;
        end
        return sel;
    endfunction

endpackage

// File: rtl/floo_vc_credit_counter.sv
// Credit counter for one downstream VC: saturating increment on credit return,
// decrement on flit send, registered availability and an overflow pulse.
module floo_vc_credit_counter
    import floo_vc_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic dec_i,
    output logic avail_o,
    output logic overflow_o
);

    localparam int unsigned     CntW   = cnt_width(Depth);
    localparam logic [CntW-1:0] CntMax = CntW'(Depth);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [CntW-1:0] cnt_r;
    logic [CntW-1:0] cnt_next_s;
    logic            avail_r;
    logic            overflow_s;

    // Next count; a simultaneous send and return leaves the count unchanged.
    always_comb begin
        cnt_next_s = cnt_r;
        overflow_s = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_r == CntMax) begin
                overflow_s = 1'b1;
            end else begin
                cnt_next_s = cnt_r + CntOne;
            end
        end else if (dec_i && !inc_i) begin
            cnt_next_s = cnt_r - CntOne;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter and availability registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r   <= CntMax;
            avail_r <= 1'b1;
        end else begin
            cnt_r   <= cnt_next_s;
            avail_r <= (cnt_next_s != {CntW{1'b0}});
        end
    end

    assign avail_o    = avail_r;
    assign overflow_o = overflow_s;

endmodule

// File: rtl/floo_vc_output_port.sv
// Credit-based VC output port: picks an output VC, stamps it into the flit and
// registers the flit onto the link. Optional sticky credit error flag built only
// when FLOO_VC_OUT_CREDIT_ERR_EN is defined.
module floo_vc_output_port
    import floo_vc_pkg::*;
#(
    parameter int unsigned NumVC      = 4,
    parameter int unsigned NumVCWidth = 2,
    parameter int unsigned VCDepth    = 2,
    parameter type         flit_t     = floo_vc_pkg::flit_t
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  flit_t                 flit_i,
    input  logic [NumVCWidth-1:0] vc_pref_i,
    input  logic [NumVC-1:0]      vc_allowed_i,
    output logic                  data_v_o,
    output flit_t                 data_o,
    input  logic                  credit_v_i,
    input  logic [NumVCWidth-1:0] credit_id_i,
    output logic [NumVC-1:0]      vc_credit_avail_o,
    output logic                  credit_err_o
);

    logic [NumVC-1:0]      avail_s;
    logic [NumVC-1:0]      elig_s;
    logic [NumVC-1:0]      inc_s;
    logic [NumVC-1:0]      dec_s;
    logic [NumVC-1:0]      ovf_s;
    logic [MaxNumVC-1:0]   elig_ext_s;
    logic [MaxVCIdW-1:0]   pref_ext_s;
    logic [MaxVCIdW-1:0]   sel_ext_s;
    logic [NumVCWidth-1:0] sel_s;
    logic                  accept_s;
    flit_t                 flit_sel_s;
    flit_t                 data_r;
    logic                  data_v_r;

    assign elig_s   = vc_allowed_i & avail_s;
    assign ready_o  = |elig_s;
    assign accept_s = valid_i & ready_o;

    // VC selection and header stamping.
    always_comb begin
        elig_ext_s              = {MaxNumVC{1'b0}};
        elig_ext_s[NumVC-1:0]   = elig_s;
        pref_ext_s              = MaxVCIdW'(vc_pref_i);
        sel_ext_s               = fvada_select(elig_ext_s, pref_ext_s);
        sel_s                   = NumVCWidth'(sel_ext_s);
        flit_sel_s              = flit_i;
        flit_sel_s.hdr.vc_id    = sel_s;
    end

    for (genvar v = 0; v < NumVC; v++) begin : gen_vc
        // Out-of-range credit ids match no VC and are thereby ignored.
        assign dec_s[v] = accept_s && (sel_s == NumVCWidth'(v));
        assign inc_s[v] = credit_v_i && (credit_id_i == NumVCWidth'(v));

        floo_vc_credit_counter #(
            .Depth (VCDepth)
        ) u_credit_counter (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .inc_i      (inc_s[v]),
            .dec_i      (dec_s[v]),
            .avail_o    (avail_s[v]),
            .overflow_o (ovf_s[v])
        );
    end

    // Link output register; no backpressure so it loads every accepted flit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_v_r <= 1'b0;
            data_r   <= '0;
        end else begin
            data_v_r <= accept_s;
            if (accept_s) begin
                data_r <= flit_sel_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign data_v_o          = data_v_r;
    assign data_o            = data_r;
    assign vc_credit_avail_o = avail_s;

`ifdef FLOO_VC_OUT_CREDIT_ERR_EN
    logic range_err_s;
    logic credit_err_r;

    assign range_err_s = credit_v_i && (32'(credit_id_i) >= NumVC);

    // Sticky protocol error; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_err_r <= 1'b0;
        end else if (range_err_s || (|ovf_s)) begin
            credit_err_r <= 1'b1;
        end else begin
            credit_err_r <= credit_err_r;
        end
    end

    assign credit_err_o = credit_err_r;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ^ovf_s;
    assign credit_err_o = 1'b0;
`endif

endmodule
